// File: rtl/ip_filter_table_reg_ctrl_pkg.sv
// Shared constants for the filter table register initiator:
// register offsets, command codes, status bits, FSM states.
package ip_filter_table_reg_ctrl_pkg;

  localparam logic [1:0] OFF_ENTRY_IP   = 2'd0;
  localparam logic [1:0] OFF_ENTRY_ADDR = 2'd1;
  localparam logic [1:0] OFF_COMMAND    = 2'd2;
  localparam logic [1:0] OFF_STATUS     = 2'd3;

  localparam logic [31:0] CMD_READ  = 32'd1;
  localparam logic [31:0] CMD_WRITE = 32'd2;

  localparam int STS_BUSY    = 0;
  localparam int STS_OVERRUN = 1;
  localparam int STS_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/ip_filter_table_reg_ctrl.sv
// Register-bus initiator for the filter table rd/wr ports.
// Optional ack timeout: define IP_FILTER_TBL_TIMEOUT_EN.
module ip_filter_table_reg_ctrl
  import ip_filter_table_reg_ctrl_pkg::*;
#(
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [1:0]                reg_addr,
  input  logic [31:0]               reg_wr_data,
  output logic                      reg_ack,
  output logic [31:0]               reg_rd_data,
  output logic [LUT_DEPTH_BITS-1:0] table_rd_addr,
  output logic                      table_rd_req,
  input  logic [31:0]               table_rd_ip,
  input  logic                      table_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] table_wr_addr,
  output logic                      table_wr_req,
  output logic [31:0]               table_wr_ip,
  input  logic                      table_wr_ack
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                    state_q, state_d;
  logic [31:0]               entry_ip_q, entry_ip_d;
  logic [LUT_DEPTH_BITS-1:0] entry_addr_q, entry_addr_d;
  logic [LUT_DEPTH_BITS-1:0] tbl_addr_q, tbl_addr_d;
  logic [31:0]               tbl_ip_q, tbl_ip_d;
  logic                      ovr_q, ovr_d;
  logic                      reg_ack_q;
  logic [31:0]               reg_rd_data_q, reg_rd_data_d;

  logic        wr_acc, rd_acc;
  logic        cmd_rd, cmd_wr, accept;
  logic        sts_wr, busy;
  logic        rd_hit, wr_hit;
  logic        tmo_hit, tmo_flag;
  logic [31:0] status;

  assign wr_acc = reg_req & ~reg_rd_wr_L;
  assign rd_acc = reg_req & reg_rd_wr_L;
  assign sts_wr = wr_acc & (reg_addr == OFF_STATUS);
  assign cmd_rd = wr_acc & (reg_addr == OFF_COMMAND)
                & (reg_wr_data == CMD_READ);
  assign cmd_wr = wr_acc & (reg_addr == OFF_COMMAND)
                & (reg_wr_data == CMD_WRITE);
  assign busy   = (state_q != ST_IDLE);
  assign accept = ~busy & (cmd_rd | cmd_wr);
  assign rd_hit = (state_q == ST_RD_WAIT) & table_rd_ack;
  assign wr_hit = (state_q == ST_WR_WAIT) & table_wr_ack;

`ifdef IP_FILTER_TBL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;

  assign tmo_hit  = busy & ~rd_hit & ~wr_hit
                  & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign tmo_flag = tmo_q;

  // Wait-cycle counter (held at 0 in IDLE) and sticky flag.
  always_comb begin
    tmo_cnt_d = busy ? tmo_cnt_q + 1'b1 : '0;
    tmo_d     = tmo_q;
    if (sts_wr && reg_wr_data[STS_TIMEOUT]) tmo_d = 1'b0;
    if (tmo_hit) tmo_d = 1'b1;
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  // Next-state logic for the table transaction FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_rd)      state_d = ST_RD_WAIT;
        else if (cmd_wr) state_d = ST_WR_WAIT;
      end
      ST_RD_WAIT: if (rd_hit || tmo_hit) state_d = ST_IDLE;
      ST_WR_WAIT: if (wr_hit || tmo_hit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Register file updates, command latch and read mux.
  always_comb begin
    entry_ip_d    = entry_ip_q;
    entry_addr_d  = entry_addr_q;
    tbl_addr_d    = tbl_addr_q;
    tbl_ip_d      = tbl_ip_q;
    ovr_d         = ovr_q;
    status        = '0;
    reg_rd_data_d = '0;

    if (wr_acc && reg_addr == OFF_ENTRY_IP)
      entry_ip_d = reg_wr_data;
    if (rd_hit)
      entry_ip_d = table_rd_ip;
    if (wr_acc && reg_addr == OFF_ENTRY_ADDR)
      entry_addr_d = reg_wr_data[LUT_DEPTH_BITS-1:0];

    if (accept) begin
      tbl_addr_d = entry_addr_q;
      tbl_ip_d   = entry_ip_q;
    end

    if (sts_wr && reg_wr_data[STS_OVERRUN]) ovr_d = 1'b0;
    if (busy && (cmd_rd || cmd_wr))         ovr_d = 1'b1;

    status[STS_BUSY]    = busy;
    status[STS_OVERRUN] = ovr_q;
    status[STS_TIMEOUT] = tmo_flag;

    if (rd_acc) begin
      unique case (reg_addr)
        OFF_ENTRY_IP:   reg_rd_data_d = entry_ip_q;
        OFF_ENTRY_ADDR: reg_rd_data_d = 32'(entry_addr_q);
        OFF_COMMAND:    reg_rd_data_d = '0;
        OFF_STATUS:     reg_rd_data_d = status;
      endcase
    end
  end

  // Register file, table request latches and bus response.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_ip_q    <= '0;
      entry_addr_q  <= '0;
      tbl_addr_q    <= '0;
      tbl_ip_q      <= '0;
      ovr_q         <= 1'b0;
      reg_ack_q     <= 1'b0;
      reg_rd_data_q <= '0;
    end else begin
      entry_ip_q    <= entry_ip_d;
      entry_addr_q  <= entry_addr_d;
      tbl_addr_q    <= tbl_addr_d;
      tbl_ip_q      <= tbl_ip_d;
      ovr_q         <= ovr_d;
      reg_ack_q     <= reg_req;
      reg_rd_data_q <= reg_rd_data_d;
    end
  end

  assign reg_ack       = reg_ack_q;
  assign reg_rd_data   = reg_rd_data_q;
  assign table_rd_req  = (state_q == ST_RD_WAIT);
  assign table_wr_req  = (state_q == ST_WR_WAIT);
  assign table_rd_addr = tbl_addr_q;
  assign table_wr_addr = tbl_addr_q;
  assign table_wr_ip   = tbl_ip_q;

endmodule
